// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: write-side controller for the 32x32 register file.
// Merges single-cycle ALU results with buffered long-latency LSU results
// into one registered regfile write per cycle. ALU has fixed priority.
// A busy scoreboard stalls issue on hazards against outstanding LSU writes.
// Optional build macro: WB_STARVE_GUARD_EN. When it is defined, an alu_ready
// output is added and the FIFO is forced to win after 3 consecutive losses.
module regfile_wb_ctrl #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_waddr,
  input  logic [DW-1:0] alu_wdata,
  input  logic          lsu_valid,
  output logic          lsu_ready,
  input  logic [AW-1:0] lsu_waddr,
  input  logic [DW-1:0] lsu_wdata,
  input  logic          issue_valid,
  input  logic          issue_long,
  input  logic [AW-1:0] issue_rd,
  input  logic [AW-1:0] issue_rs,
  input  logic [AW-1:0] issue_rt,
  output logic          stall,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic [DW-1:0] wdata
`ifdef WB_STARVE_GUARD_EN
  ,
  output logic          alu_ready
`endif
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;
  localparam int NREG = 1 << AW;

  typedef logic [AW+DW-1:0] entry_t;

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            lsu_ready_q, lsu_ready_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic            we_q, we_d;
  logic [AW-1:0]   waddr_q, waddr_d;
  logic [DW-1:0]   wdata_q, wdata_d;

  logic            push, pop, fifo_empty, alu_win, force_fifo, issue_set;
  logic [AW-1:0]   head_addr;
  logic [DW-1:0]   head_data;

  assign head_addr = mem_q[rd_ptr_q][AW+DW-1:DW];
  assign head_data = mem_q[rd_ptr_q][DW-1:0];

  assign lsu_ready = lsu_ready_q;
  assign we        = we_q;
  assign waddr     = waddr_q;
  assign wdata     = wdata_q;

`ifdef WB_STARVE_GUARD_EN
  logic [1:0] starve_q, starve_d;

  // After three straight cycles of the FIFO losing to the ALU, hand it the port once.
  assign force_fifo = (starve_q == 2'd3);
  assign alu_ready  = !force_fifo;

  // Count consecutive cycles where a waiting FIFO head lost to the ALU.
  always_comb begin
    starve_d = starve_q;
    if (pop || fifo_empty) begin
      starve_d = 2'd0;
    end else if (alu_win) begin
      starve_d = starve_q + 2'd1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_q <= 2'd0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign force_fifo = 1'b0;
`endif

  // Arbitration, FIFO bookkeeping, scoreboard update and hazard stall.
  always_comb begin
    fifo_empty = (count_q == '0);
    push       = lsu_valid && lsu_ready_q;
    alu_win    = alu_valid && !force_fifo;
    pop        = !alu_win && !fifo_empty;

    stall     = issue_valid && (busy_q[issue_rs] || busy_q[issue_rt] || busy_q[issue_rd]);
    issue_set = issue_valid && !stall && issue_long && (issue_rd != '0);

    // Idle cycles keep the last address/data on the port.
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (alu_win) begin
      we_d    = (alu_waddr != '0);
      waddr_d = alu_waddr;
      wdata_d = alu_wdata;
    end else if (pop) begin
      we_d    = (head_addr != '0);
      waddr_d = head_addr;
      wdata_d = head_data;
    end

    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    // Ready is registered, so a pop from a full FIFO reopens it one cycle later.
    lsu_ready_d = (count_d != CW'(DEPTH));

    // A new long issue to the same register outranks the retiring write.
    busy_d = busy_q;
    if (pop) begin
      busy_d[head_addr] = 1'b0;
    end
    if (issue_set) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {lsu_waddr, lsu_wdata};
    end
  end

  // Control and write-port registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      lsu_ready_q <= 1'b1;
      busy_q      <= '0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      lsu_ready_q <= lsu_ready_d;
      busy_q      <= busy_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
    end
  end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Bench for regfile_wb_ctrl: queue-based reference model, a per-cycle
// compare process, and directed scenarios with literal expectations.
// Build with WB_STARVE_GUARD_EN defined to cover the alu_ready variant.
module tb_regfile_wb_ctrl;

  localparam int DEPTH = 4;
`ifdef WB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_waddr;
  logic [31:0] alu_wdata;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_waddr;
  logic [31:0] lsu_wdata;
  logic        issue_valid;
  logic        issue_long;
  logic [4:0]  issue_rd;
  logic [4:0]  issue_rs;
  logic [4:0]  issue_rt;
  logic        stall;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
`ifdef WB_STARVE_GUARD_EN
  logic        alu_ready;
`endif

  regfile_wb_ctrl #(.DEPTH(DEPTH), .AW(5), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready),
    .lsu_waddr(lsu_waddr), .lsu_wdata(lsu_wdata),
    .issue_valid(issue_valid), .issue_long(issue_long),
    .issue_rd(issue_rd), .issue_rs(issue_rs), .issue_rt(issue_rt),
    .stall(stall), .we(we), .waddr(waddr), .wdata(wdata)
`ifdef WB_STARVE_GUARD_EN
    , .alu_ready(alu_ready)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  bit checks_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  bit          busy_m[32];
  bit          exp_we;
  logic [4:0]  exp_waddr;
  logic [31:0] exp_wdata;
  bit          addr_known;
  bit          exp_ready;
  int          starve_m;

  bit   m_acc, m_st, m_force, m_nonempty, m_popped, m_alu_won;
  ent_t m_e;

  function automatic bit model_stall();
    return issue_valid && (busy_m[issue_rs] || busy_m[issue_rt] || busy_m[issue_rd]);
  endfunction

  task automatic model_write(input logic [4:0] a, input logic [31:0] d);
    exp_we = (a != 5'd0);
    if (a != 5'd0) begin
      exp_waddr  = a;
      exp_wdata  = d;
      addr_known = 1'b1;
    end else begin
      addr_known = 1'b0;
    end
  endtask

  always @(posedge clk) begin
    if (!rst) begin
      q.delete();
      foreach (busy_m[i]) busy_m[i] = 1'b0;
      exp_we = 1'b0; exp_waddr = '0; exp_wdata = '0;
      addr_known = 1'b1; exp_ready = 1'b1; starve_m = 0;
    end else begin
      m_acc      = lsu_valid && exp_ready;
      m_st       = model_stall();
      m_force    = GUARD && (starve_m == 3);
      m_nonempty = (q.size() > 0);
      m_popped   = 1'b0;
      m_alu_won  = 1'b0;
      if (alu_valid && !m_force) begin
        model_write(alu_waddr, alu_wdata);
        m_alu_won = 1'b1;
      end else if (m_nonempty) begin
        m_e = q.pop_front();
        model_write(m_e.a, m_e.d);
        busy_m[m_e.a] = 1'b0;
        m_popped = 1'b1;
      end else begin
        exp_we = 1'b0;
      end
      if (issue_valid && !m_st && issue_long && issue_rd != 5'd0) busy_m[issue_rd] = 1'b1;
      if (m_acc) q.push_back({lsu_waddr, lsu_wdata});
      exp_ready = (q.size() < DEPTH);
      if (m_popped || !m_nonempty) starve_m = 0;
      else if (m_alu_won) starve_m = starve_m + 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (checks_on) begin
      chk("cmp_we", we, exp_we);
      if (addr_known) begin
        chk("cmp_waddr", waddr, exp_waddr);
        chk("cmp_wdata", wdata, exp_wdata);
      end
      chk("cmp_lsu_ready", lsu_ready, exp_ready);
      chk("cmp_stall", stall, model_stall());
`ifdef WB_STARVE_GUARD_EN
      chk("cmp_alu_ready", alu_ready, (starve_m != 3));
`endif
      if (we === 1'b1) $display("wb  t=%0t waddr=%0d wdata=%h", $time, waddr, wdata);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b0;
    alu_valid = 1'b1; alu_waddr = 5'd5; alu_wdata = 32'h1;
    lsu_valid = 1'b0; lsu_waddr = '0; lsu_wdata = '0;
    issue_valid = 1'b1; issue_long = 1'b1; issue_rd = 5'd9; issue_rs = 5'd9; issue_rt = 5'd9;

    // Reset held two cycles with ALU traffic present.
    tick();
    checks_on = 1'b1;
    chk("rst_we", we, 0);
    chk("rst_lsu_ready", lsu_ready, 1);
    chk("rst_stall", stall, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_wdata", wdata, 0);
    tick();
    chk("rst2_we", we, 0);
    chk("rst2_stall", stall, 0);

    // First ALU write after reset release; then a write to $0.
    rst = 1'b1; issue_valid = 1'b0; issue_long = 1'b0;
    alu_wdata = 32'hDEADBEEF;
    tick();
    chk("alu_we", we, 1);
    chk("alu_waddr", waddr, 5);
    chk("alu_wdata", wdata, 32'hDEADBEEF);
    alu_waddr = 5'd0; alu_wdata = 32'h123;
    tick();
    chk("r0_we", we, 0);

    // Priority: ALU for two cycles while an LSU result waits.
    alu_waddr = 5'd3; alu_wdata = 32'hA1;
    lsu_valid = 1'b1; lsu_waddr = 5'd7; lsu_wdata = 32'h11;
    tick();
    lsu_valid = 1'b0; alu_wdata = 32'hA2;
    chk("prio1_waddr", waddr, 3);
    tick();
    chk("prio2_wdata", wdata, 32'hA2);
    alu_valid = 1'b0;
    tick();
    chk("prio3_we", we, 1);
    chk("prio3_waddr", waddr, 7);
    chk("prio3_wdata", wdata, 32'h11);
    tick();
    chk("idle_we", we, 0);

    // FIFO full: four pushes under ALU pressure, a fifth offer, then drain.
    alu_valid = 1'b1; alu_waddr = 5'd3; alu_wdata = 32'hB0;
    for (int i = 0; i < 4; i++) begin
      lsu_valid = 1'b1; lsu_waddr = 5'(10 + i); lsu_wdata = 32'(100 + i);
      tick();
    end
    lsu_waddr = 5'd20; lsu_wdata = 32'd200;
`ifndef WB_STARVE_GUARD_EN
    chk("full_ready", lsu_ready, 0);
`endif
    tick();
`ifndef WB_STARVE_GUARD_EN
    chk("full_ready_5th", lsu_ready, 0);
`endif
    lsu_valid = 1'b0; alu_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
`ifndef WB_STARVE_GUARD_EN
      chk("drain_waddr", waddr, 32'(10 + i));
      chk("drain_wdata", wdata, 32'(100 + i));
      chk("drain_ready", lsu_ready, 1);
`endif
    end
    tick();
`ifndef WB_STARVE_GUARD_EN
    chk("drain_done_we", we, 0);
`endif

    // Scoreboard: long issue to 9, dependent issue stalls until 9 retires.
    issue_valid = 1'b1; issue_long = 1'b1; issue_rd = 5'd9; issue_rs = 5'd1; issue_rt = 5'd2;
    #1 chk("sb_issue_stall", stall, 0);
    tick();
    issue_long = 1'b0; issue_rd = 5'd4; issue_rs = 5'd9; issue_rt = 5'd0;
    #1 chk("sb_raw_stall", stall, 1);
    lsu_valid = 1'b1; lsu_waddr = 5'd9; lsu_wdata = 32'h99;
    tick();
    lsu_valid = 1'b0;
    #1 chk("sb_still_stall", stall, 1);
    tick();
    chk("sb_pop_waddr", waddr, 9);
    chk("sb_pop_wdata", wdata, 32'h99);
    chk("sb_clear_stall", stall, 0);
    issue_valid = 1'b0;

    // Same-cycle pop of 9 and new long issue to 9: busy[9] must remain set.
    alu_valid = 1'b1; alu_waddr = 5'd3; alu_wdata = 32'hC0;
    lsu_valid = 1'b1; lsu_waddr = 5'd9; lsu_wdata = 32'h77;
    tick();
    lsu_valid = 1'b0;
    tick();
    alu_valid = 1'b0;
    issue_valid = 1'b1; issue_long = 1'b1; issue_rd = 5'd9; issue_rs = 5'd0; issue_rt = 5'd0;
    #1 chk("same_issue_stall", stall, 0);
    tick();
    chk("same_pop_waddr", waddr, 9);
    chk("same_pop_wdata", wdata, 32'h77);
    issue_long = 1'b0; issue_rd = 5'd0; issue_rs = 5'd9;
    #1 chk("same_busy_kept", stall, 1);
    issue_valid = 1'b0;
    lsu_valid = 1'b1; lsu_wdata = 32'h5;
    tick();
    lsu_valid = 1'b0;
    tick();
    issue_valid = 1'b1;
    #1 chk("same_cleared", stall, 0);
    issue_valid = 1'b0;

    // Reset mid-operation discards FIFO contents and busy bits.
    issue_valid = 1'b1; issue_long = 1'b1; issue_rd = 5'd12; issue_rs = 5'd0; issue_rt = 5'd0;
    tick();
    issue_valid = 1'b0;
    alu_valid = 1'b1; alu_waddr = 5'd3;
    lsu_valid = 1'b1; lsu_waddr = 5'd12; lsu_wdata = 32'h12;
    tick();
    lsu_valid = 1'b0; rst = 1'b0;
    tick();
    rst = 1'b1; alu_valid = 1'b0;
    issue_valid = 1'b1; issue_long = 1'b0; issue_rd = 5'd0; issue_rs = 5'd12; issue_rt = 5'd12;
    #1 chk("midrst_stall", stall, 0);
    tick();
    chk("midrst_we", we, 0);
    chk("midrst_ready", lsu_ready, 1);
    issue_valid = 1'b0;

`ifdef WB_STARVE_GUARD_EN
    // Starvation guard: FIFO head forced through on the 4th contended cycle.
    alu_valid = 1'b1; alu_waddr = 5'd3; alu_wdata = 32'hD0;
    lsu_valid = 1'b1; lsu_waddr = 5'd15; lsu_wdata = 32'h55;
    tick();
    lsu_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("guard_ready_hi", alu_ready, 1);
      tick();
      chk("guard_alu_waddr", waddr, 3);
    end
    chk("guard_ready_lo", alu_ready, 0);
    tick();
    chk("guard_fifo_waddr", waddr, 15);
    chk("guard_fifo_wdata", wdata, 32'h55);
    chk("guard_ready_back", alu_ready, 1);
    alu_valid = 1'b0;
`endif

    tick();
    tick();
    checks_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
